rf_writeback_arbiter: RTL and testbench

- Write-side initiator for the 32x32 register file. Owns the register file's write port (en, write address, write data).
- Merges two result producers onto the single write port: the single-cycle ALU path and the long-latency load/store path, which is buffered in a small FIFO.
- Keeps a pending-write scoreboard so issue logic can stall on read-after-write hazards against outstanding long-latency results.
- Never emits a write to x0.

---
 rtl/rf_writeback_arbiter_if.sv | 37 +++
 rtl/rf_writeback_arbiter.sv | 98 +++++++++
 tb/tb_rf_writeback_arbiter.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/rf_writeback_arbiter_if.sv
// Register-file write-side bundle: ALU and LSU result inputs, reservation/hazard
// query, and the registered write port driven by rf_writeback_arbiter.
interface rf_writeback_arbiter_if #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic              alu_valid;
    logic [4:0]        alu_rd;
    logic [DATA_W-1:0] alu_data;
    logic              lsu_valid;
    logic              lsu_ready;
    logic [4:0]        lsu_rd;
    logic [DATA_W-1:0] lsu_data;
    logic              rsv_valid;
    logic [4:0]        rsv_rd;
    logic [4:0]        chk_rs1;
    logic [4:0]        chk_rs2;
    logic              hazard;
    logic              rf_en;
    logic [4:0]        rf_wa;
    logic [DATA_W-1:0] rf_wd;
    logic [CW-1:0]     fifo_count;

    modport master (
        output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
               rsv_valid, rsv_rd, chk_rs1, chk_rs2,
        input  lsu_ready, hazard, rf_en, rf_wa, rf_wd, fifo_count
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
               rsv_valid, rsv_rd, chk_rs1, chk_rs2,
        output lsu_ready, hazard, rf_en, rf_wa, rf_wd, fifo_count
    );
endinterface

// File: rtl/rf_writeback_arbiter.sv
// Merges ALU (1-cycle, strict priority) and buffered LSU results (>=2 cycles) onto the RF write port;
// LSU is back-pressured via lsu_ready when the FIFO is full, and a busy scoreboard flags RAW hazards.
module rf_writeback_arbiter #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    rf_writeback_arbiter_if.slave bus
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef struct packed {
        logic [4:0]        rd;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t            mem [FIFO_DEPTH];
    entry_t            head;
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_ptr;
    logic [CW-1:0]     count;
    logic [31:0]       busy;
    logic [31:0]       busy_nxt;
    logic              alu_wr;
    logic              push;
    logic              pop;
    logic              ready;

    // Ready depends only on current occupancy, so a full FIFO refuses a push even while popping.
    assign ready  = !rst && (count < DEPTH_C);
    assign alu_wr = bus.alu_valid && (bus.alu_rd != 5'd0);
    assign push   = bus.lsu_valid && ready && (bus.lsu_rd != 5'd0);
    assign pop    = !alu_wr && (count != '0);
    assign head   = mem[rd_ptr];

    assign bus.lsu_ready  = ready;
    assign bus.fifo_count = count;
    assign bus.hazard     = busy[bus.chk_rs1] | busy[bus.chk_rs2];

    // A reservation landing on the edge that retires the same register must win.
    always_comb begin
        busy_nxt = busy;
        if (pop) begin
            busy_nxt[head.rd] = 1'b0;
        end
        if (bus.rsv_valid && (bus.rsv_rd != 5'd0)) begin
            busy_nxt[bus.rsv_rd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{rd: bus.lsu_rd, data: bus.lsu_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            busy       <= '0;
            bus.rf_en  <= 1'b0;
            bus.rf_wa  <= 5'd0;
            bus.rf_wd  <= '0;
        end else begin
            busy <= busy_nxt;
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            // Address/data hold their last value on idle cycles.
            if (alu_wr) begin
                bus.rf_en <= 1'b1;
                bus.rf_wa <= bus.alu_rd;
                bus.rf_wd <= bus.alu_data;
            end else if (pop) begin
                bus.rf_en <= 1'b1;
                bus.rf_wa <= head.rd;
                bus.rf_wd <= head.data;
            end else begin
                bus.rf_en <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_rf_writeback_arbiter.sv
module tb_rf_writeback_arbiter;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rf_writeback_arbiter_if #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) bus ();

    rf_writeback_arbiter #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    wr_t         m_fifo[$];
    wr_t         exp_q[$];
    logic [31:0] m_busy;
    logic [4:0]  m_wa;
    logic [31:0] m_wd;
    int          checks   = 0;
    int          failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive inputs, check combinational outputs, advance the model, check registered outputs.
    task automatic cyc(input bit av, input logic [4:0] ard, input logic [31:0] ad,
                       input bit lv, input logic [4:0] lrd, input logic [31:0] ld,
                       input bit rv, input logic [4:0] rrd,
                       input logic [4:0] rs1, input logic [4:0] rs2, output bit acc);
        bit  m_rdy;
        wr_t w;
        bus.alu_valid = av;  bus.alu_rd = ard;  bus.alu_data = ad;
        bus.lsu_valid = lv;  bus.lsu_rd = lrd;  bus.lsu_data = ld;
        bus.rsv_valid = rv;  bus.rsv_rd = rrd;
        bus.chk_rs1   = rs1; bus.chk_rs2 = rs2;
        #1;
        m_rdy = !rst && (m_fifo.size() < DEPTH);
        check("lsu_ready", bus.lsu_ready, m_rdy);
        check("hazard", bus.hazard, m_busy[rs1] | m_busy[rs2]);
        check("fifo_count", bus.fifo_count, m_fifo.size());
        acc = lv && m_rdy;
        @(posedge clk);
        if (rst) begin
            m_fifo.delete();
            exp_q.delete();
            m_busy = '0;
            m_wa   = '0;
            m_wd   = '0;
        end else begin
            if (av && ard != 5'd0) begin
                exp_q.push_back({ard, ad});
            end else if (m_fifo.size() > 0) begin
                w = m_fifo.pop_front();
                exp_q.push_back(w);
                m_busy[w.rd] = 1'b0;
            end
            if (acc && lrd != 5'd0) m_fifo.push_back({lrd, ld});
            if (rv && rrd != 5'd0) m_busy[rrd] = 1'b1;
        end
        #1;
        if (exp_q.size() > 0) begin
            w = exp_q.pop_front();
            check("rf_en", bus.rf_en, 1'b1);
            check("rf_wa", bus.rf_wa, w.rd);
            check("rf_wd", bus.rf_wd, w.data);
            m_wa = w.rd;
            m_wd = w.data;
        end else begin
            check("rf_en_idle", bus.rf_en, 1'b0);
            check("rf_wa_hold", bus.rf_wa, m_wa);
            check("rf_wd_hold", bus.rf_wd, m_wd);
        end
        check("no_x0_write", bus.rf_en && bus.rf_wa == 5'd0, 1'b0);
    endtask

    task automatic idle(input int n, input logic [4:0] rs1);
        bit a;
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, rs1, 0, a);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   a;
        int   idx;
        int   guard;
        wr_t  lsu_list[5];

        m_busy = '0; m_wa = '0; m_wd = '0;
        rst = 1'b1;
        bus.alu_valid = 0; bus.alu_rd = 0; bus.alu_data = 0;
        bus.lsu_valid = 0; bus.lsu_rd = 0; bus.lsu_data = 0;
        bus.rsv_valid = 0; bus.rsv_rd = 0; bus.chk_rs1 = 0; bus.chk_rs2 = 0;
        @(posedge clk); @(posedge clk); #1;
        check("reset_rf_en", bus.rf_en, 1'b0);
        check("reset_rf_wa", bus.rf_wa, 5'd0);
        check("reset_rf_wd", bus.rf_wd, 32'd0);
        check("reset_lsu_ready", bus.lsu_ready, 1'b0);
        idle(1, 0);
        rst = 1'b0;
        #1;
        check("ready_after_reset", bus.lsu_ready, 1'b1);

        // ALU single write, latency 1
        cyc(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, a);
        idle(2, 0);

        // Two LSU results in order
        cyc(0, 0, 0, 1, 7, 32'h11, 0, 0, 0, 0, a);
        check("lsu7_acc", a, 1'b1);
        cyc(0, 0, 0, 1, 8, 32'h22, 0, 0, 0, 0, a);
        check("lsu8_acc", a, 1'b1);
        idle(3, 0);
        check("drained", bus.fifo_count, 0);

        // ALU burst starving the LSU while the FIFO fills
        for (int i = 0; i < 5; i++) lsu_list[i] = {5'(16 + i), 32'hA000 + i};
        idx = 0;
        for (int i = 0; i < 6; i++) begin
            cyc(1, 5'(10 + i), 32'hB000 + i, idx < 5, (idx < 5) ? lsu_list[idx].rd : 5'd0,
                (idx < 5) ? lsu_list[idx].data : 32'd0, 0, 0, 0, 0, a);
            if (a) idx++;
        end
        check("fifth_blocked", idx, 4);
        check("full_not_ready", bus.lsu_ready, 1'b0);
        guard = 0;
        while (idx < 5 && guard < 20) begin
            cyc(0, 0, 0, 1, lsu_list[idx].rd, lsu_list[idx].data, 0, 0, 0, 0, a);
            if (a) idx++;
            guard++;
        end
        check("fifth_accepted", idx, 5);
        idle(6, 0);

        // Scoreboard: reserve, hazard, clear, then set-wins on the clearing edge
        cyc(0, 0, 0, 0, 0, 0, 1, 9, 0, 0, a);
        idle(2, 9);
        check("hazard_set", bus.hazard, 1'b1);
        cyc(0, 0, 0, 1, 9, 32'h99, 0, 0, 9, 0, a);
        idle(2, 9);
        check("hazard_cleared", bus.hazard, 1'b0);
        cyc(0, 0, 0, 0, 0, 0, 1, 9, 0, 9, a);
        cyc(0, 0, 0, 1, 9, 32'h98, 0, 0, 0, 9, a);
        cyc(0, 0, 0, 0, 0, 0, 1, 9, 0, 9, a);
        #1;
        check("set_wins", bus.hazard, 1'b1);
        idle(2, 9);

        // x0 handling: buffered rd=3 pops under ALU rd=0, LSU rd=0 is handshaked only
        cyc(1, 1, 32'h1, 1, 3, 32'h33, 0, 0, 0, 0, a);
        check("fifo_one", bus.fifo_count, 1);
        cyc(1, 0, 32'hBAD, 1, 0, 32'hBAD0, 0, 0, 0, 0, a);
        check("x0_lsu_handshake", a, 1'b1);
        check("x0_count", bus.fifo_count, 0);
        idle(2, 0);

        // Reset mid-operation with buffered entries and a reservation
        for (int i = 0; i < 3; i++) cyc(1, 5'(20 + i), 32'hC0 + i, 1, 5'(24 + i), 32'hD0 + i, i == 0, 4, 4, 0, a);
        check("three_buffered", bus.fifo_count, 3);
        rst = 1'b1;
        idle(1, 4);
        rst = 1'b0;
        #1;
        check("rst_count", bus.fifo_count, 0);
        check("rst_hazard", bus.hazard, 1'b0);
        check("rst_rf_en", bus.rf_en, 1'b0);
        idle(5, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
